change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Consumer end of the coin-accumulator datapath. After a vend, it takes the change amount derived from the 5-bit accumulator total and pays it out one coin at a time.
- Picks the largest denomination whose tube is not empty. Drives the coin-release mechanism through a valid/ready handshake.
- Reports completion, shortfall and mechanism timeout back to the vending controller.

Parameters:
- WIDTH, 5, width of amount and remaining (units of 5 cents; matches accumulator width)
- Q_VAL, 5, quarter value in units
- D_VAL, 2, dime value in units
- N_VAL, 1, nickel value in units
- ACK_TIMEOUT, 15, max consecutive cycles coin_valid may wait for coin_ready (2..15, 4-bit counter)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- start  input  1  1-cycle request to pay out `amount`; honoured only in IDLE
- amount  input  WIDTH  change due, captured when start is accepted
- q_empty  input  1  quarter tube empty
- d_empty  input  1  dime tube empty
- n_empty  input  1  nickel tube empty
- coin_ready  input  1  mechanism accepts current coin
- coin_valid  output  1  coin release request
- coin_sel  output  2  00 none, 01 nickel, 10 dime, 11 quarter; stable while coin_valid=1
- busy  output  1  high in any state other than IDLE
- done  output  1  1-cycle completion pulse
- short  output  1  payout ended with remaining != 0; held until next accepted start
- fault  output  1  payout aborted by handshake timeout; held until next accepted start
- remaining  output  WIDTH  units still owed; held after done

Behaviour:
- Reset (rst_n=0 at edge):
  - state=IDLE.
  - coin_valid, coin_sel, busy, done, short, fault, remaining all 0; wait counter 0.
  - Applies from any state, including mid-handshake; coin_valid is low in the cycle after the reset edge.
- States: IDLE, SELECT, DISPENSE, DONE.
- IDLE:
  - start=1 → remaining<=amount, short<=0, fault<=0, goto SELECT.
  - start in any other state is ignored (not queued).
- SELECT (one cycle). Priority evaluated on current remaining and empty flags:
  - remaining==0 → DONE (short=0).
  - else if remaining>=Q_VAL and !q_empty → coin_sel=11.
  - else if remaining>=D_VAL and !d_empty → coin_sel=10.
  - else if remaining>=N_VAL and !n_empty → coin_sel=01.
  - If a coin was chosen: coin_valid<=1, wait counter<=0, goto DISPENSE.
  - else → short<=1, goto DONE.
- DISPENSE:
  - coin_valid=1 and coin_sel held constant. Empty-flag changes are ignored until the next SELECT.
  - coin_ready=1 → transfer. remaining<=remaining−value(coin_sel); coin_valid<=0, coin_sel<=00; goto SELECT.
  - coin_ready=0 and counter==ACK_TIMEOUT−1 → fault<=1, short<=1, coin_valid<=0, coin_sel<=00, goto DONE. remaining is not decremented, so coin_valid stays high exactly ACK_TIMEOUT cycles.
  - Otherwise the counter increments.
- DONE (one cycle): done=1, busy=1, then goto IDLE. done is a registered output, high exactly one cycle.
- Latency:
  - start accepted at edge 0 → SELECT after edge 0 → coin_valid high after edge 1.
  - With coin_ready tied high: one coin per 2 cycles.
  - amount=0: done is high in the cycle after edge 1.
- Arithmetic:
  - Subtraction never underflows, because selection guarantees value<=remaining.
  - Comparisons are unsigned WIDTH-bit.
  - Max amount 31.

Decomposition:
- Shared package vend_pkg holds:
  - coin_sel encodings COIN_NONE/COIN_N/COIN_D/COIN_Q;
  - state enum disp_state_t;
  - denomination values.
- One combinational sub-module change_coin_pick:
  - inputs remaining and the three empty flags;
  - outputs coin_sel and a pick_valid flag.
  - Reusable by a future exact-change-available indicator.

Test Plan:
1. amount=17, all tubes full, coin_ready=1 → coin sequence 11,11,11,10; remaining 17→12→7→2→0; done once; short=0, fault=0; done high 2 cycles after the last transfer.
2. amount=7, q_empty=1 → coins 10,10,10,01; done, short=0, remaining=0.
3. amount=3, d_empty=1, n_empty=1 → no coin_valid; done 2 cycles after start; short=1, remaining=3.
4. amount=5, coin_ready held 0 → coin_valid=1 with coin_sel=11 for exactly 15 cycles, then drops; done next; fault=1, short=1, remaining=5.
5. amount=10, coin_ready=1; rst_n=0 while coin_valid=1 → next cycle all outputs 0, state IDLE; a later start with amount=2 dispenses 10 normally.
6. start pulsed with amount=9 while busy (mid amount=4 payout) → ignored; payout finishes 10,10 with remaining=0 and exactly one done pulse.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending datapath: coin encodings, dispenser states,
// and default denomination values in units of 5 cents.
package vend_pkg;
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_N    = 2'b01;
  localparam logic [1:0] COIN_D    = 2'b10;
  localparam logic [1:0] COIN_Q    = 2'b11;

  localparam int Q_VAL_DEF = 5;
  localparam int D_VAL_DEF = 2;
  localparam int N_VAL_DEF = 1;

  typedef enum logic [1:0] {IDLE, SELECT, DISPENSE, DONE} disp_state_t;
endpackage

// File: rtl/change_coin_pick.sv
// Greedy coin choice: largest denomination that fits the remaining amount and
// whose tube still has coins. pick_valid=0 means nothing can be paid.
module change_coin_pick
  import vend_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int Q_VAL = Q_VAL_DEF,
  parameter int D_VAL = D_VAL_DEF,
  parameter int N_VAL = N_VAL_DEF
) (
  input  logic [WIDTH-1:0] remaining,
  input  logic             q_empty,
  input  logic             d_empty,
  input  logic             n_empty,
  output logic [1:0]       coin_sel,
  output logic             pick_valid
);
  localparam logic [WIDTH-1:0] QV = WIDTH'(Q_VAL);
  localparam logic [WIDTH-1:0] DV = WIDTH'(D_VAL);
  localparam logic [WIDTH-1:0] NV = WIDTH'(N_VAL);

  always_comb begin
    coin_sel   = COIN_NONE;
    pick_valid = 1'b0;
    if (remaining >= QV && !q_empty) begin
      coin_sel   = COIN_Q;
      pick_valid = 1'b1;
    end else if (remaining >= DV && !d_empty) begin
      coin_sel   = COIN_D;
      pick_valid = 1'b1;
    end else if (remaining >= NV && !n_empty) begin
      coin_sel   = COIN_N;
      pick_valid = 1'b1;
    end
  end
endmodule

// File: rtl/change_dispenser.sv
// Pays out change one coin at a time over a valid/ready handshake to the
// coin-release mechanism; reports done, shortfall and handshake timeout.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int WIDTH       = 5,
  parameter int Q_VAL       = Q_VAL_DEF,
  parameter int D_VAL       = D_VAL_DEF,
  parameter int N_VAL       = N_VAL_DEF,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] amount,
  input  logic             q_empty,
  input  logic             d_empty,
  input  logic             n_empty,
  input  logic             coin_ready,
  output logic             coin_valid,
  output logic [1:0]       coin_sel,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic             fault,
  output logic [WIDTH-1:0] remaining
);
  localparam logic [3:0] WAIT_LAST = 4'(ACK_TIMEOUT - 1);

  disp_state_t      state;
  logic [3:0]       wait_cnt;
  logic [1:0]       pick_sel;
  logic             pick_valid;
  logic [WIDTH-1:0] coin_val;

  change_coin_pick #(
    .WIDTH(WIDTH), .Q_VAL(Q_VAL), .D_VAL(D_VAL), .N_VAL(N_VAL)
  ) u_pick (
    .remaining (remaining),
    .q_empty   (q_empty),
    .d_empty   (d_empty),
    .n_empty   (n_empty),
    .coin_sel  (pick_sel),
    .pick_valid(pick_valid)
  );

  always_comb begin
    case (coin_sel)
      COIN_Q:  coin_val = WIDTH'(Q_VAL);
      COIN_D:  coin_val = WIDTH'(D_VAL);
      COIN_N:  coin_val = WIDTH'(N_VAL);
      default: coin_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      coin_valid <= 1'b0;
      coin_sel   <= COIN_NONE;
      busy       <= 1'b0;
      done       <= 1'b0;
      short      <= 1'b0;
      fault      <= 1'b0;
      remaining  <= '0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= amount;
            short     <= 1'b0;
            fault     <= 1'b0;
            busy      <= 1'b1;
            state     <= SELECT;
          end
        end
        SELECT: begin
          if (pick_valid) begin
            coin_valid <= 1'b1;
            coin_sel   <= pick_sel;
            wait_cnt   <= '0;
            state      <= DISPENSE;
          end else begin
            // nothing payable: clean finish if fully paid, shortfall otherwise
            short <= (remaining != '0);
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DISPENSE: begin
          if (coin_ready) begin
            remaining  <= remaining - coin_val;
            coin_valid <= 1'b0;
            coin_sel   <= COIN_NONE;
            state      <= SELECT;
          end else if (wait_cnt == WAIT_LAST) begin
            fault      <= 1'b1;
            short      <= 1'b1;
            coin_valid <= 1'b0;
            coin_sel   <= COIN_NONE;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: phase-level greedy payout model compared every
// cycle, plus directed scenarios with hand-computed coin sequences.
module tb_change_dispenser;
  localparam int ACK = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] amount = '0;
  logic       q_empty = 1'b0, d_empty = 1'b0, n_empty = 1'b0;
  logic       coin_ready = 1'b0;
  logic       coin_valid, busy, done, short, fault;
  logic [1:0] coin_sel;
  logic [4:0] remaining;

  change_dispenser #(.WIDTH(5), .ACK_TIMEOUT(ACK)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .amount(amount),
    .q_empty(q_empty), .d_empty(d_empty), .n_empty(n_empty),
    .coin_ready(coin_ready), .coin_valid(coin_valid), .coin_sel(coin_sel),
    .busy(busy), .done(done), .short(short), .fault(fault),
    .remaining(remaining)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 choosing, 2 offering a coin, 3 finished.
  int m_ph = 0, m_rem = 0, m_val = 0, m_wait = 0;
  bit m_short = 0, m_fault = 0;

  function automatic int greedy(input int rem, input bit qe, input bit de, input bit ne);
    if (rem >= 5 && !qe) return 5;
    if (rem >= 2 && !de) return 2;
    if (rem >= 1 && !ne) return 1;
    return 0;
  endfunction

  function automatic int code_of(input int val);
    return (val == 5) ? 3 : (val == 2) ? 2 : (val == 1) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    int v;
    if (!rst_n) begin
      m_ph = 0; m_rem = 0; m_val = 0; m_wait = 0; m_short = 0; m_fault = 0;
    end else begin
      case (m_ph)
        0: if (start) begin m_rem = amount; m_short = 0; m_fault = 0; m_ph = 1; end
        1: begin
          v = greedy(m_rem, q_empty, d_empty, n_empty);
          if (v == 0) begin m_short = (m_rem != 0); m_ph = 3; end
          else begin m_val = v; m_wait = 0; m_ph = 2; end
        end
        2: begin
          if (coin_ready) begin m_rem -= m_val; m_val = 0; m_ph = 1; end
          else if (m_wait == ACK - 1) begin m_fault = 1; m_short = 1; m_val = 0; m_ph = 3; end
          else m_wait++;
        end
        default: m_ph = 0;
      endcase
    end
  end

  bit cmp_en = 0;
  int cyc = 0, n_done = 0, cv_cnt = 0, last_xfer = 0, done_cyc = 0, start_cyc = 0;
  int seq = 0, seq_len = 0;

  always @(negedge clk) begin
    cyc++;
    if (cmp_en) begin
      chk("coin_valid", coin_valid, m_ph == 2);
      chk("coin_sel", coin_sel, code_of(m_val));
      chk("busy", busy, m_ph != 0);
      chk("done", done, m_ph == 3);
      chk("short", short, m_short);
      chk("fault", fault, m_fault);
      chk("remaining", remaining, m_rem);
    end
    if (start && !busy) start_cyc = cyc;
    if (coin_valid) cv_cnt++;
    if (coin_valid && coin_ready) begin
      seq = seq * 4 + coin_sel; seq_len++; last_xfer = cyc;
    end
    if (done) begin n_done++; done_cyc = cyc; end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    seq = 0; seq_len = 0; n_done = 0; cv_cnt = 0;
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && n_done == 0; i++) step();
    chk("done_seen", n_done > 0, 1);
    step();
  endtask

  task automatic pay(input int amt, input bit qe, input bit de, input bit ne, input bit rdy);
    q_empty = qe; d_empty = de; n_empty = ne; coin_ready = rdy;
    clear_log();
    amount = 5'(amt); start = 1'b1;
    step();
    start = 1'b0;
    wait_done(200);
  endtask

  initial begin
    rst_n = 1'b0;
    step();
    cmp_en = 1;
    step();
    chk("rst_valid", coin_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rem", remaining, 0);
    rst_n = 1'b1;
    step();

    // 1: 17 with all tubes full
    pay(17, 0, 0, 0, 1);
    chk("t1_seq", seq, 8'hFE);
    chk("t1_len", seq_len, 4);
    chk("t1_rem", remaining, 0);
    chk("t1_done_cnt", n_done, 1);
    chk("t1_short", short, 0);
    chk("t1_fault", fault, 0);
    chk("t1_done_lat", done_cyc - last_xfer, 2);

    // 2: 7 with no quarters
    pay(7, 1, 0, 0, 1);
    chk("t2_seq", seq, 8'hA9);
    chk("t2_len", seq_len, 4);
    chk("t2_rem", remaining, 0);
    chk("t2_short", short, 0);

    // 3: 3 with only quarters available
    pay(3, 0, 1, 1, 1);
    chk("t3_cv_cnt", cv_cnt, 0);
    chk("t3_done_lat", done_cyc - start_cyc, 2);
    chk("t3_short", short, 1);
    chk("t3_rem", remaining, 3);

    // 4: mechanism never acknowledges
    pay(5, 0, 0, 0, 0);
    chk("t4_cv_cnt", cv_cnt, ACK);
    chk("t4_len", seq_len, 0);
    chk("t4_fault", fault, 1);
    chk("t4_short", short, 1);
    chk("t4_rem", remaining, 5);

    // 5: reset in the middle of a handshake
    q_empty = 0; d_empty = 0; n_empty = 0; coin_ready = 1'b1;
    clear_log();
    amount = 5'd10; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && !coin_valid; i++) step();
    chk("t5_cv_before_rst", coin_valid, 1);
    rst_n = 1'b0;
    step();
    chk("t5_cv", coin_valid, 0);
    chk("t5_sel", coin_sel, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_short", short, 0);
    chk("t5_fault", fault, 0);
    chk("t5_rem", remaining, 0);
    rst_n = 1'b1;
    step();
    pay(2, 0, 0, 0, 1);
    chk("t5_seq", seq, 2);
    chk("t5_len", seq_len, 1);
    chk("t5_rem_after", remaining, 0);

    // 6: start while busy is ignored
    clear_log();
    coin_ready = 1'b1;
    amount = 5'd4; start = 1'b1;
    step();
    start = 1'b0;
    step();
    amount = 5'd9; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(200);
    for (int i = 0; i < 4; i++) step();
    chk("t6_seq", seq, 4'hA);
    chk("t6_len", seq_len, 2);
    chk("t6_rem", remaining, 0);
    chk("t6_done_cnt", n_done, 1);
    chk("t6_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
